posit_div_seq: RTL and testbench

- Iterative, multi-cycle posit divider. Computes OUT = IN1 / IN2 for posits of width N and exponent size ES.
- Inverse operation of the combinational posit multiplier datapath; shares its decode stage and its round/encode stage.
- Divides the mantissas by restoring division, one quotient bit per cycle, to keep area low.
- Uses a start/valid handshake so it can sit beside the multiplier in the arithmetic unit.

---
 rtl/posit_pkg.sv | 27 ++
 rtl/Data_Extraction.sv | 66 ++++++
 rtl/posit_mant_div.sv | 61 ++++++
 rtl/posit_div_seq.sv | 144 ++++++++++++++
 tb/tb_posit_div_seq.sv | 97 +++++++++
 5 files changed

// File: rtl/posit_pkg.sv
// Shared definitions for the posit arithmetic unit.
//   state_e       : sequencer states of the iterative divider
//   posit_const() : special encodings (zero, NaR, maxpos, minpos) for an n-bit posit
//   ROUND_MODE    : rounding mode used by the round/encode stage
package posit_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, DIVIDE, ROUND, DONE} state_e;

    typedef enum logic [1:0] {PC_ZERO, PC_NAR, PC_MAXPOS, PC_MINPOS} posit_const_e;

    typedef enum logic {RND_RNE, RND_RTZ} rnd_mode_e;
    localparam rnd_mode_e ROUND_MODE = RND_RNE;

    // Result is 64 bits wide; callers size-cast it down to N.
    function automatic logic [63:0] posit_const(input int n, input posit_const_e kind);
        logic [63:0] r;
        r = '0;
        case (kind)
            PC_NAR:    r = 64'd1 << (n - 1);
            PC_MAXPOS: r = (64'd1 << (n - 1)) - 64'd1;
            PC_MINPOS: r = 64'd1;
            default:   r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/Data_Extraction.sv
// Posit operand decode shared by the multiplier and the divider.
//   i_in    : posit word
//   o_sign  : sign bit
//   o_k     : signed regime value
//   o_exp   : exponent field (missing bits read as 0)
//   o_mant  : N-bit mantissa, hidden 1 in the MSB
//   o_nar   : operand is NaR
//   o_zero  : operand is zero
// o_k/o_exp/o_mant are meaningless when o_nar or o_zero is set.
module Data_Extraction
    import posit_pkg::*;
#(
    parameter int N  = 32,
    parameter int ES = 4,
    parameter int RS = $clog2(N)
) (
    input  logic                 [N-1:0]  i_in,
    output logic                          o_sign,
    output logic signed          [RS+1:0] o_k,
    output logic                 [ES-1:0] o_exp,
    output logic                 [N-1:0]  o_mant,
    output logic                          o_nar,
    output logic                          o_zero
);

    localparam logic [N-1:0] NAR = N'(posit_const(N, PC_NAR));
    localparam logic signed [RS+1:0] KONE = (RS+2)'(1);

    logic [N-2:0]    w_xin;
    logic            w_rc;
    logic [RS:0]     w_run;
    logic            w_stop;
    logic [RS:0]     w_shamt;
    logic [N-2:0]    w_body;
    logic signed [RS+1:0] w_kpos;

    assign o_sign = i_in[N-1];
    assign o_nar  = (i_in == NAR);
    assign o_zero = (i_in == '0);

    // Magnitude below the sign bit; only the low N-1 bits of -in are needed.
    assign w_xin = o_sign ? (~i_in[N-2:0] + (N-1)'(1)) : i_in[N-2:0];
    assign w_rc  = w_xin[N-2];

    // Regime run length: identical bits starting right below the sign.
    always_comb begin
        w_run  = '0;
        w_stop = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!w_stop) begin
                if (w_xin[i] == w_rc) w_run = w_run + (RS+1)'(1);
                else                  w_stop = 1'b1;
            end
        end
    end

    assign w_kpos  = $signed({1'b0, w_run});
    assign o_k     = w_rc ? (w_kpos - KONE) : -w_kpos;

    // Drop run plus terminator; exponent then fraction are left-aligned.
    assign w_shamt = w_run + (RS+1)'(1);
    assign w_body  = w_xin << w_shamt;
    assign o_exp   = w_body[N-2 -: ES];
    assign o_mant  = {1'b1, w_body[N-2-ES:0], {ES{1'b0}}};

endmodule

// File: rtl/posit_mant_div.sv
// Restoring mantissa divider, one quotient bit per step.
//   i_load     : latch dividend/divisor, clear quotient and counter
//   i_step     : perform one trial subtraction
//   i_dividend : N-bit mantissa in [1,2)
//   i_divisor  : N-bit mantissa in [1,2)
//   o_quot     : N+2-bit quotient, 1 integer bit + N+1 fraction bits
//   o_rem_nz   : final remainder nonzero (sticky source)
//   o_done     : high during the last step (counter == N+1)
module posit_mant_div #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_load,
    input  logic           i_step,
    input  logic [N-1:0]   i_dividend,
    input  logic [N-1:0]   i_divisor,
    output logic [N+1:0]   o_quot,
    output logic           o_rem_nz,
    output logic           o_done
);

    localparam int CW = $clog2(N + 2);

    logic [N:0]    r_rem;
    logic [N-1:0]  r_div;
    logic [N+1:0]  r_quot;
    logic [CW-1:0] r_cnt;

    logic [N+1:0]  w_sub;
    logic          w_ge;
    logic [N:0]    w_rem_nxt;

    // Remainder stays below 2*divisor, so N+1 bits plus a borrow bit suffice.
    assign w_sub     = {1'b0, r_rem} - {2'b00, r_div};
    assign w_ge      = ~w_sub[N+1];
    assign w_rem_nxt = (w_ge ? w_sub[N:0] : r_rem) << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_div  <= '0;
            r_quot <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_rem  <= {1'b0, i_dividend};
            r_div  <= i_divisor;
            r_quot <= '0;
            r_cnt  <= '0;
        end else if (i_step) begin
            r_rem  <= w_rem_nxt;
            r_quot <= {r_quot[N:0], w_ge};
            r_cnt  <= r_cnt + CW'(1);
        end
    end

    assign o_quot   = r_quot;
    assign o_rem_nz = |r_rem;
    assign o_done   = i_step && (r_cnt == CW'(N + 1));

endmodule

// File: rtl/posit_div_seq.sv
// Iterative posit divider: OUT = IN1 / IN2.
//   clk, rst   : clock, synchronous active-high reset
//   start      : request, sampled in IDLE only; IN1/IN2 captured then
//   OUT        : quotient, held until the next result
//   valid      : one-cycle pulse when OUT is new
//   busy       : state != IDLE
//   div_zero   : pulses with valid when IN2 was zero
// Normal latency N+5 cycles from the start cycle, specials 2 cycles.
module posit_div_seq
    import posit_pkg::*;
#(
    parameter int N  = 32,
    parameter int ES = 4,
    parameter int RS = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] IN1,
    input  logic [N-1:0] IN2,
    output logic [N-1:0] OUT,
    output logic         valid,
    output logic         busy,
    output logic         div_zero
);

    localparam int SW = RS + ES + 3;   // signed scale width
    localparam int XW = N + ES + 3;    // regime seed + exponent + fraction
    localparam int PW = XW + N;        // room for the regime shift
    localparam logic [N-1:0] NAR    = N'(posit_const(N, PC_NAR));
    localparam logic [N-1:0] ZERO   = N'(posit_const(N, PC_ZERO));
    localparam logic [N-1:0] MAXPOS = N'(posit_const(N, PC_MAXPOS));
    localparam logic [N-1:0] MINPOS = N'(posit_const(N, PC_MINPOS));
    localparam logic signed [SW-1:0] KMAX = SW'(N - 2);
    localparam logic signed [SW-1:0] KMIN = -KMAX;

    state_e        r_state;
    logic [N-1:0]  r_in1, r_in2, r_out;
    logic          r_valid, r_dz;

    logic                 w_s1, w_s2, w_nar1, w_nar2, w_z1, w_z2;
    logic signed [RS+1:0] w_k1, w_k2;
    logic [ES-1:0]        w_e1, w_e2;
    logic [N-1:0]         w_m1, w_m2;
    logic [N+1:0]         w_quot;
    logic                 w_rem_nz, w_div_done, w_load, w_step;

    Data_Extraction #(.N(N), .ES(ES), .RS(RS)) u_dec1 (
        .i_in(r_in1), .o_sign(w_s1), .o_k(w_k1), .o_exp(w_e1),
        .o_mant(w_m1), .o_nar(w_nar1), .o_zero(w_z1));

    Data_Extraction #(.N(N), .ES(ES), .RS(RS)) u_dec2 (
        .i_in(r_in2), .o_sign(w_s2), .o_k(w_k2), .o_exp(w_e2),
        .o_mant(w_m2), .o_nar(w_nar2), .o_zero(w_z2));

    assign w_load = (r_state == LOAD);
    assign w_step = (r_state == DIVIDE);

    posit_mant_div #(.N(N)) u_mdiv (
        .clk(clk), .rst(rst), .i_load(w_load), .i_step(w_step),
        .i_dividend(w_m1), .i_divisor(w_m2), .o_quot(w_quot),
        .o_rem_nz(w_rem_nz), .o_done(w_div_done));

    // Scale and normalization: quotient lies in (0.5, 2), one shift at most.
    logic signed [SW-1:0] w_sc1, w_sc2, w_scale, w_kr;
    logic                 w_qshift;
    logic [N:0]           w_frac;

    assign w_sc1    = $signed({w_k1[RS+1], w_k1, w_e1});
    assign w_sc2    = $signed({w_k2[RS+1], w_k2, w_e2});
    assign w_qshift = ~w_quot[N+1];
    assign w_scale  = w_sc1 - w_sc2 - $signed({{(SW-1){1'b0}}, w_qshift});
    assign w_frac   = w_qshift ? {w_quot[N-1:0], 1'b0} : w_quot[N:0];
    assign w_kr     = w_scale >>> ES;

    // Encode: seed 10 (k>=0) or 01 (k<0), arithmetic shift replicates the
    // leading bit to build the regime run; shift is k or -k-1 (= ~k).
    logic [SW-1:0]        w_sh;
    logic [XW-1:0]        w_x;
    logic signed [PW-1:0] w_y;
    logic [N-2:0]         w_body;
    logic                 w_guard, w_stk, w_up;
    logic [N-1:0]         w_rnd, w_mag, w_result;

    assign w_sh    = w_kr[SW-1] ? ~w_kr : w_kr;
    assign w_x     = {(w_kr[SW-1] ? 2'b01 : 2'b10), w_scale[ES-1:0], w_frac};
    assign w_y     = $signed({w_x, {N{1'b0}}}) >>> w_sh;
    assign w_body  = w_y[PW-1 -: N-1];
    assign w_guard = w_y[PW-N];
    assign w_stk   = (|w_y[PW-N-1:0]) | w_rem_nz;
    assign w_up    = (ROUND_MODE == RND_RNE) ? (w_guard & (w_body[0] | w_stk)) : 1'b0;
    assign w_rnd   = {1'b0, w_body} + N'(w_up);

    // Round-up carry into the sign position would give NaR: clamp instead.
    assign w_mag    = ((w_kr > KMAX) || w_rnd[N-1]) ? MAXPOS :
                      (w_kr < KMIN)                 ? MINPOS : w_rnd;
    assign w_result = (w_s1 ^ w_s2) ? -w_mag : w_mag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_in1   <= '0;
            r_in2   <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_dz    <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_in1   <= IN1;
                    r_in2   <= IN2;
                    r_state <= LOAD;
                end
                LOAD: begin
                    if (w_nar1 || w_nar2) begin
                        r_out <= NAR; r_valid <= 1'b1; r_state <= DONE;
                    end else if (w_z2) begin
                        r_out <= NAR; r_dz <= 1'b1; r_valid <= 1'b1; r_state <= DONE;
                    end else if (w_z1) begin
                        r_out <= ZERO; r_valid <= 1'b1; r_state <= DONE;
                    end else begin
                        r_state <= DIVIDE;
                    end
                end
                DIVIDE: if (w_div_done) r_state <= ROUND;
                ROUND: begin
                    r_out   <= w_result;
                    r_valid <= 1'b1;
                    r_state <= DONE;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign OUT      = r_out;
    assign valid    = r_valid;
    assign div_zero = r_dz;
    assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_posit_div_seq.sv
module tb_posit_div_seq;

    logic        clk, rst, start;
    logic [15:0] IN1, IN2, OUT;
    logic        valid, busy, div_zero;

    int n_chk = 0;
    int n_fail = 0;

    posit_div_seq #(.N(16), .ES(1)) dut (
        .clk(clk), .rst(rst), .start(start), .IN1(IN1), .IN2(IN2),
        .OUT(OUT), .valid(valid), .busy(busy), .div_zero(div_zero));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle. poke>0 pulses start with a
    // different operand pair in that cycle of the operation.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_o, input logic exp_dz,
                          input int exp_lat, input int poke);
        int   lat;
        logic bsy_ok;
        IN1 = a; IN2 = b; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = -1; bsy_ok = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!busy) bsy_ok = 1'b0;
            if (valid) begin lat = c; break; end
            if (c == poke) begin start = 1'b1; IN1 = 16'h7FFF; IN2 = 16'h0001; end
            else start = 1'b0;
        end
        start = 1'b0;
        chk({tag, ".lat"},  32'(lat), 32'(exp_lat));
        chk({tag, ".out"},  32'(OUT), 32'(exp_o));
        chk({tag, ".dz"},   32'(div_zero), 32'(exp_dz));
        chk({tag, ".busy"}, 32'(bsy_ok), 32'd1);
        @(negedge clk);
        chk({tag, ".vdrop"}, 32'(valid), 32'd0);
        chk({tag, ".idle"},  32'(busy), 32'd0);
    endtask

    initial begin
        int stray;
        rst = 1'b1; start = 1'b1; IN1 = 16'h5000; IN2 = 16'h4000;
        repeat (3) @(negedge clk);
        chk("rst.out",   32'(OUT), 32'h0);
        chk("rst.valid", 32'(valid), 32'h0);
        chk("rst.busy",  32'(busy), 32'h0);
        chk("rst.dz",    32'(div_zero), 32'h0);
        rst = 1'b0; start = 1'b0;

        run_op("two",    16'h5000, 16'h4000, 16'h5000, 1'b0, 21, 0);
        run_op("third",  16'h4000, 16'h5800, 16'h2555, 1'b0, 21, 0);
        run_op("one",    16'h4000, 16'h4000, 16'h4000, 1'b0, 21, 0);
        run_op("neg",    16'hC000, 16'h3000, 16'hB000, 1'b0, 21, 0);
        run_op("divz",   16'h4000, 16'h0000, 16'h8000, 1'b1, 2, 0);
        run_op("zero",   16'h0000, 16'h5000, 16'h0000, 1'b0, 2, 0);
        run_op("nar",    16'h8000, 16'h4000, 16'h8000, 1'b0, 2, 0);
        run_op("satmax", 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 21, 0);
        run_op("satmin", 16'h0001, 16'h7FFF, 16'h0001, 1'b0, 21, 0);
        run_op("poke",   16'h4000, 16'h5800, 16'h2555, 1'b0, 21, 5);
        // Second call drives start in the first IDLE cycle after DONE.
        run_op("b2b.a",  16'hC000, 16'h3000, 16'hB000, 1'b0, 21, 0);
        run_op("b2b.b",  16'h5000, 16'h4000, 16'h5000, 1'b0, 21, 0);

        // Reset in the middle of DIVIDE.
        IN1 = 16'h4000; IN2 = 16'h5800; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst.busy",  32'(busy), 32'h0);
        chk("mrst.valid", 32'(valid), 32'h0);
        chk("mrst.out",   32'(OUT), 32'h0);
        rst = 1'b0;
        stray = 0;
        repeat (30) begin
            @(negedge clk);
            if (valid || busy) stray++;
        end
        chk("mrst.stray", 32'(stray), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
